// File: rtl/controle_portao_pkg.sv
// Shared definitions for the gate-motor controller: state codes and a
// parameter sanity check evaluated at elaboration time.
package controle_portao_pkg;

  localparam int W_ESTADO = 3;

  typedef enum logic [W_ESTADO-1:0] {
    INICIO   = 3'd0,
    FECHADO  = 3'd1,
    ABRINDO  = 3'd2,
    ABERTO   = 3'd3,
    FECHANDO = 3'd4,
    PARADO   = 3'd5,
    ERRO     = 3'd6
  } estado_t;

  // True when both timers fit in the counter and meet their minimum values.
  function automatic bit parametros_validos(input int tempo_aberto,
                                            input int tempo_mov,
                                            input int w_cont);
    longint maximo_s;
    longint limite_s;
    maximo_s = (tempo_aberto > tempo_mov) ? longint'(tempo_aberto) : longint'(tempo_mov);
    if (w_cont >= 32'sd62) begin
      limite_s = 64'sh3FFF_FFFF_FFFF_FFFF;
    end else begin
      limite_s = (64'sd1 <<< w_cont) - 64'sd1;
    end
    return (tempo_aberto >= 32'sd1) && (tempo_mov >= 32'sd2) &&
           (w_cont >= 32'sd1) && ((maximo_s - 64'sd1) <= limite_s);
  endfunction

endpackage

// File: rtl/controle_portao_fsm_if.sv
// Sensor/button inputs and motor-driver outputs of one gate controller.
interface controle_portao_fsm_if;
  import controle_portao_pkg::*;

  logic                fim_aberto;
  logic                fim_fechado;
  logic                sensor;
  logic                cmd;
  logic                abrir;
  logic                fechar;
  logic [W_ESTADO-1:0] estado;
  logic                erro;

  modport master (
    output fim_aberto, fim_fechado, sensor, cmd,
    input  abrir, fechar, estado, erro
  );

  modport slave (
    input  fim_aberto, fim_fechado, sensor, cmd,
    output abrir, fechar, estado, erro
  );
endinterface

// File: rtl/controle_portao_fsm_detector_borda.sv
// Rising-edge detector for a level already synchronous to clk; a held level
// produces a single one-cycle pulse.
module detector_borda (
  input  logic clk,
  input  logic rst,
  input  logic entrada,
  output logic pulso
);

  logic entrada_q_r;

  // Delay the input one cycle so the edge can be seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      entrada_q_r <= 1'b0;
    end else begin
      entrada_q_r <= entrada;
    end
  end

  assign pulso = entrada & ~entrada_q_r;

endmodule

// File: rtl/controle_portao_fsm.sv
// Sequential gate-motor controller: auto-close, reversal on obstruction,
// stop/resume by button, movement watchdog and a sticky fault state.
module controle_portao_fsm
  import controle_portao_pkg::*;
#(
  parameter int TEMPO_ABERTO = 10,
  parameter int TEMPO_MOV    = 50,
  parameter int W_CONT       = 16
) (
  input logic                 clk,
  input logic                 rst,
  controle_portao_fsm_if.slave bus
);

  if (!parametros_validos(TEMPO_ABERTO, TEMPO_MOV, W_CONT)) begin : g_param_invalido
    $error("controle_portao_fsm: TEMPO_ABERTO/TEMPO_MOV out of range for W_CONT");
  end

  localparam logic [W_CONT-1:0] LIM_ABERTO = W_CONT'(TEMPO_ABERTO - 1);
  localparam logic [W_CONT-1:0] LIM_MOV    = W_CONT'(TEMPO_MOV - 1);
  localparam logic [W_CONT-1:0] CONT_MAX   = {W_CONT{1'b1}};
  localparam logic [W_CONT-1:0] CONT_ZERO  = {W_CONT{1'b0}};
  localparam logic [W_CONT-1:0] CONT_UM    = W_CONT'(1);

  estado_t           estado_r;
  estado_t           prox_s;
  logic [W_CONT-1:0] cont_r;
  logic              dir_r;
  logic              dir_prox_s;
  logic              rearme_s;
  logic              pulso_s;
  logic              abrir_s;
  logic              fechar_s;
  logic              erro_s;
  logic              abrir_r;
  logic              fechar_r;
  logic              erro_r;

  detector_borda u_detector_borda (
    .clk     (clk),
    .rst     (rst),
    .entrada (bus.cmd),
    .pulso   (pulso_s)
  );

  // Next-state selection and decode of the outputs for the next state.
  always_comb begin
    prox_s     = estado_r;
    rearme_s   = 1'b0;
    dir_prox_s = dir_r;
    abrir_s    = 1'b0;
    fechar_s   = 1'b0;
    erro_s     = 1'b0;

    if ((estado_r != ERRO) && bus.fim_aberto && bus.fim_fechado) begin
      prox_s = ERRO;
    end else begin
      case (estado_r)
        INICIO: begin
          if (bus.fim_fechado) begin
            prox_s = FECHADO;
          end else if (bus.fim_aberto) begin
            prox_s = ABERTO;
          end else begin
            prox_s = FECHANDO;
          end
        end
        FECHADO: begin
          if (pulso_s) begin
            prox_s = ABRINDO;
          end else begin
            prox_s = FECHADO;
          end
        end
        // Obstruction is deliberately ignored while opening.
        ABRINDO: begin
          if (bus.fim_aberto) begin
            prox_s = ABERTO;
          end else if (pulso_s) begin
            prox_s = PARADO;
          end else if (cont_r == LIM_MOV) begin
            prox_s = ERRO;
          end else begin
            prox_s = ABRINDO;
          end
        end
        // An obstacle re-arms the auto-close delay rather than blocking it.
        ABERTO: begin
          if (bus.sensor) begin
            prox_s   = ABERTO;
            rearme_s = 1'b1;
          end else if (pulso_s || (cont_r == LIM_ABERTO)) begin
            prox_s = FECHANDO;
          end else begin
            prox_s = ABERTO;
          end
        end
        FECHANDO: begin
          if (bus.fim_fechado) begin
            prox_s = FECHADO;
          end else if (bus.sensor) begin
            prox_s = ABRINDO;
          end else if (pulso_s) begin
            prox_s = PARADO;
          end else if (cont_r == LIM_MOV) begin
            prox_s = ERRO;
          end else begin
            prox_s = FECHANDO;
          end
        end
        // Resume in the opposite direction of the interrupted motion.
        PARADO: begin
          if (pulso_s) begin
            prox_s = dir_r ? FECHANDO : ABRINDO;
          end else begin
            prox_s = PARADO;
          end
        end
        ERRO: begin
          prox_s = ERRO;
        end
        default: begin
          prox_s = ERRO;
        end
      endcase
    end

    if (prox_s == ABRINDO) begin
      dir_prox_s = 1'b1;
    end else if (prox_s == FECHANDO) begin
      dir_prox_s = 1'b0;
    end else begin
      dir_prox_s = dir_r;
    end

    abrir_s  = (prox_s == ABRINDO);
    fechar_s = (prox_s == FECHANDO);
    erro_s   = (prox_s == ERRO);
  end

  // State, direction, timing counter and registered motor outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_r <= INICIO;
      cont_r   <= CONT_ZERO;
      dir_r    <= 1'b0;
      abrir_r  <= 1'b0;
      fechar_r <= 1'b0;
      erro_r   <= 1'b0;
    end else begin
      estado_r <= prox_s;
      dir_r    <= dir_prox_s;
      abrir_r  <= abrir_s;
      fechar_r <= fechar_s;
      erro_r   <= erro_s;
      if ((prox_s != estado_r) || rearme_s) begin
        cont_r <= CONT_ZERO;
      end else if (cont_r != CONT_MAX) begin
        cont_r <= cont_r + CONT_UM;
      end else begin
        cont_r <= cont_r;
      end
    end
  end

  assign bus.abrir  = abrir_r;
  assign bus.fechar = fechar_r;
  assign bus.erro   = erro_r;
  assign bus.estado = estado_r;

endmodule
